// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth signed multiplier control and register datapath.
// Sequences add/sub/init commands to an external registered adder REG_WIDTH+1 bits wide.
module booth_sequencer #(
    parameter int REG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [REG_WIDTH-1:0]   multiplicand,
    input  logic [REG_WIDTH-1:0]   multiplier,
    output logic                   busy,
    output logic                   done,
    output logic [2*REG_WIDTH-1:0] product,
    output logic [REG_WIDTH:0]     adder_a,
    output logic [REG_WIDTH:0]     adder_b,
    input  logic [REG_WIDTH:0]     adder_c,
    output logic                   ctl_add,
    output logic                   ctl_sub,
    output logic                   ctl_init
);
    localparam int CW = $clog2(REG_WIDTH + 1);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EVAL, S_WAIT, S_SHIFT, S_DONE} state_t;
    state_t state, state_next;
    logic [REG_WIDTH:0] a;
    logic [REG_WIDTH-1:0] m, q;
    logic qm1;
    logic [CW-1:0] count;
    logic last;
    assign adder_a = a;
    assign adder_b = {m[REG_WIDTH-1], m};
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign last = count == CW'(1);
    always_comb begin
        state_next = state;
        ctl_add = 1'b0;
        ctl_sub = 1'b0;
        ctl_init = 1'b0;
        case (state)
            S_IDLE: state_next = start ? S_INIT : S_IDLE;
            S_INIT: begin
                ctl_init = 1'b1;
                state_next = S_EVAL;
            end
            S_EVAL: begin
                // {Q0,Qm1}: 10 -> subtract (110), 01 -> add (100), else skip
                ctl_add = q[0] ^ qm1;
                ctl_sub = q[0] & ~qm1;
                state_next = (q[0] ^ qm1) ? S_WAIT : S_SHIFT;
            end
            S_WAIT: state_next = S_SHIFT;
            S_SHIFT: state_next = last ? S_DONE : S_EVAL;
            default: state_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a <= '0;
            q <= '0;
            qm1 <= 1'b0;
            m <= '0;
            count <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (start) begin
                    m <= multiplicand;
                    q <= multiplier;
                    qm1 <= 1'b0;
                    a <= '0;
                    count <= CW'(REG_WIDTH);
                end
                S_WAIT: a <= adder_c;
                S_SHIFT: begin
                    {a, q, qm1} <= {a[REG_WIDTH], a, q};
                    count <= count - CW'(1);
                    // product taken from the post-shift {A[W-1:0],Q}
                    if (last) product <= {a, q[REG_WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: directed bench with a behavioural registered adder and product scoreboard.
module tb_booth_sequencer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic busy, done, ctl_add, ctl_sub, ctl_init;
    logic [2*W-1:0] product;
    logic [W:0] adder_a, adder_b, adder_c;
    int checks = 0;
    int passed = 0;
    int failed = 0;
    int n_add, n_sub, n_init, n_bad;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    booth_sequencer #(.REG_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .adder_a(adder_a), .adder_b(adder_b), .adder_c(adder_c),
        .ctl_add(ctl_add), .ctl_sub(ctl_sub), .ctl_init(ctl_init)
    );

    // Registered adder without reset: result valid the cycle after the command.
    always @(posedge clk) begin
        case ({ctl_add, ctl_sub, ctl_init})
            3'b100: adder_c <= adder_a + adder_b;
            3'b110: adder_c <= adder_a - adder_b;
            3'b001: adder_c <= '0;
            default: ;
        endcase
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] mv, input logic [W-1:0] qv);
        logic signed [2*W-1:0] p;
        p = $signed(mv) * $signed(qv);
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tally();
        case ({ctl_add, ctl_sub, ctl_init})
            3'b100: n_add++;
            3'b110: n_sub++;
            3'b001: n_init++;
            3'b000: ;
            default: n_bad++;
        endcase
    endtask

    task automatic launch(input logic [W-1:0] mv, input logic [W-1:0] qv, input bit hold);
        @(negedge clk);
        multiplicand = mv;
        multiplier = qv;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(mv, qv));
        #1;
        if (!hold) start = 1'b0;
        check("accept busy", busy, 1);
    endtask

    // Entered at #1 into cycle 1 (INIT); runs to the done pulse and one cycle beyond.
    task automatic wait_done(input string tag, input int exp_cyc, input int exp_add,
                             input int exp_sub, input bit hold, input bit toggle);
        int k;
        logic [2*W-1:0] prev, expv;
        prev = product;
        n_add = 0; n_sub = 0; n_init = 0; n_bad = 0;
        k = 1;
        tally();
        while (!done && k < 200) begin
            if (toggle) begin
                start = ~start;
                multiplicand = W'($urandom);
                multiplier = W'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
            if (!done) tally();
            if (toggle && k == 5) check({tag, " product held"}, product, prev);
        end
        if (!hold) start = 1'b0;
        expv = exp_q.size() > 0 ? exp_q.pop_front() : ~product;
        check({tag, " done cycle"}, k, exp_cyc);
        check({tag, " product"}, product, expv);
        check({tag, " n_init"}, n_init, 1);
        check({tag, " n_add"}, n_add, exp_add);
        check({tag, " n_sub"}, n_sub, exp_sub);
        check({tag, " bad cmd"}, n_bad, 0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {busy, done}, 2'b00);
        check({tag, " product kept"}, product, expv);
    endtask

    initial begin
        int nd;
        // reset with random inputs
        start = 1'b1;
        multiplicand = W'($urandom);
        multiplier = W'($urandom);
        #1;
        check("rst outputs", {busy, done, ctl_add, ctl_sub, ctl_init}, 0);
        check("rst product", product, 0);
        check("rst adder_a", adder_a, 0);
        check("rst adder_b", adder_b, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst held", {busy, done, ctl_add, ctl_sub, ctl_init}, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst idle", {busy, done}, 0);

        launch(8'd7, 8'd3, 0);
        wait_done("7x3", 20, 1, 1, 0, 0);
        launch(8'd7, 8'd0, 0);
        wait_done("7x0", 18, 0, 0, 0, 0);
        launch(-8'sd5, 8'd7, 0);
        wait_done("-5x7", 20, 1, 1, 0, 0);
        launch(8'h80, 8'h80, 0);
        wait_done("-128x-128", 19, 0, 1, 0, 0);
        launch(8'h80, 8'd127, 0);
        wait_done("-128x127", 20, 1, 1, 0, 0);

        // start held high: next operation only after DONE then IDLE
        launch(8'd7, 8'd3, 1);
        wait_done("held1", 20, 1, 1, 1, 0);
        @(posedge clk);
        exp_q.push_back(model(8'd7, 8'd3));
        #1;
        check("held restart", {busy, ctl_init}, 2'b11);
        wait_done("held2", 20, 1, 1, 0, 0);

        // start and operands toggled while busy
        launch(8'd3, 8'hFE, 0);
        wait_done("toggle", 19, 0, 1, 0, 1);

        // abort in cycle 10
        launch(-8'sd5, 8'd7, 0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort state", {busy, done, ctl_add, ctl_sub, ctl_init}, 0);
        check("abort product", product, 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        check("abort no done", nd, 0);
        launch(8'd7, 8'd3, 0);
        wait_done("post abort 7x3", 20, 1, 1, 0, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
